// File: rtl/model_layer_node_unit_divider.sv
`default_nettype none
// =============================================================================
// Module  : model_layer_node_unit_divider
// Brief   : float32 divider; restoring mantissa division (one quotient bit per
//           cycle, MSB first) followed by guard/sticky rounding, ties not rounded up.
// Revision: 1.0 - initial release
// =============================================================================
module model_layer_node_unit_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [4:0]  C_LAST_ITER = 5'd25;
    localparam logic [31:0] C_INF_MAG   = {1'b0, 8'hFF, 23'd0};

    state_t       state_q, state_d;
    logic [4:0]   cnt_q,   cnt_d;
    logic [25:0]  quo_q,   quo_d;
    logic [24:0]  rem_q,   rem_d;
    logic [23:0]  dvs_q,   dvs_d;
    logic [7:0]   ea_q,    ea_d;
    logic [7:0]   eb_q,    eb_d;
    logic         sign_q,  sign_d;
    logic [31:0]  c_q,     c_d;
    logic         dbz_q,   dbz_d;
    logic         ov_q,    ov_d;

    // Restoring step: the kept remainder is always below the divisor (< 2^24),
    // so shifting it left still fits the 25-bit register.
    logic         w_step_bit;
    logic [24:0]  w_step_diff;
    logic [24:0]  w_step_rem;

    assign w_step_bit  = (rem_q >= {1'b0, dvs_q});
    assign w_step_diff = rem_q - {1'b0, dvs_q};
    assign w_step_rem  = w_step_bit ? w_step_diff : rem_q;

    logic              w_sign_r;
    logic              w_a_zero;
    logic              w_b_zero;
    logic [22:0]       w_mant_base;
    logic              w_guard;
    logic              w_sticky;
    logic signed [9:0] w_exp_base;
    logic [23:0]       w_mant_inc;
    logic [22:0]       w_mant_rnd;
    logic signed [9:0] w_exp_rnd;
    logic [31:0]       w_rnd_c;

    assign w_sign_r = a[31] ^ b[31];
    assign w_a_zero = (a[30:0] == 31'd0);
    assign w_b_zero = (b[30:0] == 31'd0);

    always_comb begin
        w_mant_base = quo_q[25] ? quo_q[24:2] : quo_q[23:1];
        w_guard     = quo_q[25] ? quo_q[1]    : quo_q[0];
        w_sticky    = (quo_q[25] & quo_q[0]) | (rem_q != 25'd0);
        w_exp_base  = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
                      + (quo_q[25] ? 10'sd127 : 10'sd126);
        w_mant_inc  = {1'b0, w_mant_base} + 24'd1;
        w_mant_rnd  = w_mant_base;
        w_exp_rnd   = w_exp_base;
        if (w_guard && w_sticky) begin
            // a carry out of the increment wraps the fraction to zero
            w_mant_rnd = w_mant_inc[22:0];
            if (w_mant_inc[23]) begin
                w_exp_rnd = w_exp_base + 10'sd1;
            end
        end
        if (w_exp_rnd >= 10'sd255) begin
            w_rnd_c = {sign_q, C_INF_MAG[30:0]};
        end else if (w_exp_rnd <= 10'sd0) begin
            w_rnd_c = {sign_q, 31'd0};
        end else begin
            w_rnd_c = {sign_q, w_exp_rnd[7:0], w_mant_rnd};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        sign_d  = sign_q;
        c_d     = c_q;
        dbz_d   = dbz_q;
        ov_d    = ov_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d = w_sign_r;
                    if (w_b_zero) begin
                        c_d     = {w_sign_r, C_INF_MAG[30:0]};
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else if (w_a_zero) begin
                        c_d     = 32'd0;
                        dbz_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        rem_d   = {2'b01, a[22:0]};
                        dvs_d   = {1'b1, b[22:0]};
                        ea_d    = a[30:23];
                        eb_d    = b[30:23];
                        quo_d   = 26'd0;
                        cnt_d   = 5'd0;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                quo_d = {quo_q[24:0], w_step_bit};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == C_LAST_ITER) begin
                    rem_d   = w_step_rem;
                    state_d = ROUND;
                end else begin
                    rem_d = {w_step_rem[23:0], 1'b0};
                end
            end
            ROUND: begin
                c_d     = w_rnd_c;
                dbz_d   = 1'b0;
                ov_d    = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                // special results arrive here one cycle before out_valid rises
                ov_d = 1'b1;
                if (ov_q && out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ov_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            quo_q   <= 26'd0;
            rem_q   <= 25'd0;
            dvs_q   <= 24'd0;
            ea_q    <= 8'd0;
            eb_q    <= 8'd0;
            sign_q  <= 1'b0;
            c_q     <= 32'd0;
            dbz_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            sign_q  <= sign_d;
            c_q     <= c_d;
            dbz_q   <= dbz_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = ov_q;
    assign c           = c_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_model_layer_node_unit_divider.sv
`default_nettype none
// =============================================================================
// Module  : tb_model_layer_node_unit_divider
// Brief   : randomized and directed checks of the float32 divider against a
//           plain-arithmetic reference model.
// Revision: 1.0 - initial release
// =============================================================================
module tb_model_layer_node_unit_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic [31:0] c;
    logic        out_valid;
    logic        div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    model_layer_node_unit_divider dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .c          (c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: {div_by_zero, c} from the divide/round rules using integer math.
    function automatic logic [32:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        logic                 sr;
        longint unsigned      num, den, q, r, mant;
        int                   e;
        bit                   g, st;
        sr = x[31] ^ y[31];
        if (y[30:0] == 31'd0) return {1'b1, sr, 8'hFF, 23'd0};
        if (x[30:0] == 31'd0) return 33'd0;
        num = (longint'(x[22:0]) + 64'd8388608) * 64'd33554432;
        den = longint'(y[22:0]) + 64'd8388608;
        q = num / den;
        r = num % den;
        if (q >= 64'd33554432) begin
            mant = (q >> 2) & 64'h7FFFFF;
            g    = ((q >> 1) & 64'd1) != 0;
            st   = ((q & 64'd1) != 0) || (r != 0);
            e    = int'(x[30:23]) - int'(y[30:23]) + 127;
        end else begin
            mant = (q >> 1) & 64'h7FFFFF;
            g    = (q & 64'd1) != 0;
            st   = (r != 0);
            e    = int'(x[30:23]) - int'(y[30:23]) + 126;
        end
        if (g && st) mant = mant + 1;
        if (mant == 64'h800000) begin
            mant = 0;
            e    = e + 1;
        end
        if (e >= 255) return {1'b0, sr, 8'hFF, 23'd0};
        if (e <= 0)   return {1'b0, sr, 31'd0};
        return {1'b0, sr, e[7:0], mant[22:0]};
    endfunction

    // Presents one request, then scrambles a/b (and optionally keeps in_valid
    // high with junk) while waiting for out_valid. lat = edges after T0.
    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input bit junk,
                          output logic [31:0] rc, output logic rdbz, output int lat,
                          output bit accepted);
        accepted = in_ready;
        a = oa;
        b = ob;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = $urandom;
        b = $urandom;
        in_valid = junk;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        rc   = c;
        rdbz = div_by_zero;
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || c !== 32'd0 || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b c=%h dbz=%b, required 1 0 00000000 0",
                     in_ready, out_valid, c, div_by_zero);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] va[7] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000,
                               32'h00000000, 32'h7F000000, 32'h00800000};
        logic [31:0] vb[7] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h40000000,
                               32'h00000000, 32'h3E800000, 32'h7F000000};
        logic [31:0] vc[7] = '{32'h40400000, 32'h3EAAAAAB, 32'hFF800000, 32'h00000000,
                               32'h7F800000, 32'h7F800000, 32'h00000000};
        logic        vz[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int          vl[7] = '{27, 27, 1, 1, 1, 27, 27};
        logic [31:0] rc;
        logic        rdbz;
        int          lat;
        bit          acc;
        for (int i = 0; i < 7; i++) begin
            run_op(va[i], vb[i], 1'b0, rc, rdbz, lat, acc);
            n_vec++;
            if (!acc || rc !== vc[i] || rdbz !== vz[i] || lat != vl[i]) begin
                n_err++;
                $display("FAIL directed_%0d: acc=%0d c=%h dbz=%b lat=%0d, required acc=1 c=%h dbz=%b lat=%0d",
                         i, acc, rc, rdbz, lat, vc[i], vz[i], vl[i]);
            end
            release_result();
            n_vec++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL directed_release_%0d: in_ready=%b out_valid=%b, required 1 0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] oa, ob, rc;
        logic [32:0] exp_r;
        logic        rdbz;
        int          lat, exp_lat;
        bit          acc;
        for (int i = 0; i < 200; i++) begin
            oa = {$urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)), 23'($urandom)};
            ob = {$urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)), 23'($urandom)};
            if ($urandom_range(0, 9) == 0) oa[30:0] = 31'd0;
            if ($urandom_range(0, 9) == 0) ob[30:0] = 31'd0;
            if ($urandom_range(0, 3) == 0) ob[22:0] = oa[22:0];
            exp_r   = ref_div(oa, ob);
            exp_lat = (oa[30:0] == 31'd0 || ob[30:0] == 31'd0) ? 1 : 27;
            run_op(oa, ob, ($urandom_range(0, 1) == 1), rc, rdbz, lat, acc);
            n_vec++;
            if (!acc || rc !== exp_r[31:0] || rdbz !== exp_r[32] || lat != exp_lat) begin
                n_err++;
                $display("FAIL random_%0d a=%h b=%h: acc=%0d c=%h dbz=%b lat=%0d, required c=%h dbz=%b lat=%0d",
                         i, oa, ob, acc, rc, rdbz, lat, exp_r[31:0], exp_r[32], exp_lat);
            end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rc;
        logic        rdbz;
        int          lat;
        bit          acc;
        bit          bad;
        run_op(32'h3F800000, 32'h40400000, 1'b1, rc, rdbz, lat, acc);
        n_vec++;
        if (!acc || rc !== 32'h3EAAAAAB || lat != 27) begin
            n_err++;
            $display("FAIL bp_result: c=%h lat=%0d, required c=3eaaaaab lat=27", rc, lat);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (c !== 32'h3EAAAAAB || out_valid !== 1'b1 || in_ready !== 1'b0 || div_by_zero !== 1'b0)
                bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL bp_hold: c=%h out_valid=%b in_ready=%b, required 3eaaaaab 1 0",
                     c, out_valid, in_ready);
        end
        release_result();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rc;
        logic        rdbz;
        int          lat;
        bit          acc;
        bit          seen;
        a = 32'h40C00000;
        b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || c !== 32'd0 || div_by_zero !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_op: out_valid=%b in_ready=%b c=%h dbz=%b, required 0 1 00000000 0",
                     out_valid, in_ready, c, div_by_zero);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_discard: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
        run_op(32'h40C00000, 32'h40000000, 1'b0, rc, rdbz, lat, acc);
        n_vec++;
        if (!acc || rc !== 32'h40400000 || rdbz !== 1'b0 || lat != 27) begin
            n_err++;
            $display("FAIL reset_restart: c=%h dbz=%b lat=%0d, required 40400000 0 27", rc, rdbz, lat);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
